// File: rtl/mmio_uart_tx_if.sv
// MMIO write/read bus between the CPU load/store unit and a responder page.
//   i_we    : single-cycle write strobe
//   i_addr  : byte address
//   i_wdata : write data
//   i_size  : access size (byte/half/word)
//   o_rdata : combinational read data from the responder
`timescale 1ns/1ps
interface mmio_uart_tx_if;
  logic        i_we;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [2:0]  i_size;
  logic [31:0] o_rdata;

  modport master (output i_we, output i_addr, output i_wdata, output i_size, input o_rdata);
  modport slave  (input i_we, input i_addr, input i_wdata, input i_size, output o_rdata);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, one 4 KiB MMIO page.
// Ports:
//   i_clk     : core clock, rising edge
//   i_rst     : asynchronous active-high reset
//   bus       : MMIO responder (we/addr/wdata/size in, combinational rdata out)
//   o_uart_tx : serial line, idle high, driven from a register
//   o_busy    : FIFO non-empty or a frame in flight
// Registers (offset = addr[3:2]): 0 TXDATA, 1 STATUS, 2 CTRL, 3 BAUD_DIV.
// Optional feature macro UART_TX_PARITY_EN: adds CTRL[1] parity enable,
// CTRL[2] odd select and a PARITY bit between the data bits and stop bit.
`timescale 1ns/1ps
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_3000,
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  mmio_uart_tx_if.slave  bus,
  output logic           o_uart_tx,
  output logic           o_busy
);
  localparam int unsigned AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW        = AW + 1;
  localparam int unsigned RESET_DIV = CLK_HZ / BAUD - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            ovf_q, en_q;
  logic [15:0]     div_q, bit_div_q, baud_cnt_q;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q;
  logic            line_q, line_d;
  logic            par_en_q, odd_q;

  // Bus decode
  logic       sel_c, wr_c, push_req_c, push_ok_c, ovf_set_c;
  logic [1:0] offs_c;
  assign sel_c      = (bus.i_addr & 32'hFFFF_F000) == BASE_ADDR;
  assign offs_c     = bus.i_addr[3:2];
  assign wr_c       = bus.i_we & sel_c;
  assign push_req_c = wr_c & (offs_c == 2'd0);
  assign push_ok_c  = push_req_c & (count_q < CW'(FIFO_DEPTH));
  assign ovf_set_c  = push_req_c & ~push_ok_c;

  logic empty_c, full_c, bit_end_c, pop_c, bit_start_c;
  assign empty_c     = (count_q == '0);
  assign full_c      = (count_q == CW'(FIFO_DEPTH));
  assign bit_end_c   = (baud_cnt_q == bit_div_q);
  assign bit_start_c = pop_c | ((state_q != S_IDLE) & bit_end_c);

  // Size and the upper write-data bits carry no information for this page
  logic unused_c;
  assign unused_c = ^{bus.i_size, bus.i_wdata[31:16]};

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en_q && !empty_c) state_d = S_START;
      S_START: if (bit_end_c) state_d = S_DATA;
      S_DATA: if (bit_end_c && idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
        state_d = par_en_q ? S_PARITY : S_STOP;
`else
        state_d = S_STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end_c) state_d = S_STOP;
`endif
      S_STOP:  if (bit_end_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs of the FSM: pop strobe, bit index and next line level
  always_comb begin
    pop_c  = 1'b0;
    idx_d  = idx_q;
    line_d = 1'b1;
    if (state_q == S_IDLE)                pop_c = en_q & ~empty_c;
    if (state_q == S_START && bit_end_c)  idx_d = 3'd0;
    if (state_q == S_DATA && bit_end_c)   idx_d = idx_q + 3'd1;
    case (state_d)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shreg_q[idx_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: line_d = (^shreg_q) ^ odd_q;
`endif
      default:  line_d = 1'b1;
    endcase
  end

  // Shifter datapath; bit period is latched at each bit start
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      line_q     <= 1'b1;
      idx_q      <= 3'd0;
      shreg_q    <= 8'd0;
      baud_cnt_q <= 16'd0;
      bit_div_q  <= 16'(RESET_DIV);
    end else begin
      line_q <= line_d;
      idx_q  <= idx_d;
      if (pop_c) shreg_q <= fifo_mem[rd_ptr_q];
      if (bit_start_c) begin
        baud_cnt_q <= 16'd0;
        bit_div_q  <= div_q;
      end else if (state_q != S_IDLE) begin
        baud_cnt_q <= baud_cnt_q + 16'd1;
      end
    end
  end

  // FIFO storage (no reset needed; validity tracked by count)
  always_ff @(posedge i_clk) begin
    if (push_ok_c) fifo_mem[wr_ptr_q] <= bus.i_wdata[7:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)     rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok_c, pop_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Control/status registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      en_q     <= 1'b1;
      par_en_q <= 1'b0;
      odd_q    <= 1'b0;
      div_q    <= 16'(RESET_DIV);
      ovf_q    <= 1'b0;
    end else begin
      if (wr_c) begin
        case (offs_c)
          2'd1: if (bus.i_wdata[3]) ovf_q <= 1'b0;
          2'd2: begin
            en_q <= bus.i_wdata[0];
`ifdef UART_TX_PARITY_EN
            par_en_q <= bus.i_wdata[1];
            odd_q    <= bus.i_wdata[2];
`endif
          end
          2'd3:    div_q <= bus.i_wdata[15:0];
          default: ;
        endcase
      end
      if (ovf_set_c) ovf_q <= 1'b1;
    end
  end

  // Combinational read mux; zero outside the page
  always_comb begin
    bus.o_rdata = 32'd0;
    if (sel_c) begin
      case (offs_c)
        2'd1:    bus.o_rdata = {15'd0, 9'(count_q), 4'd0, ovf_q, empty_c, full_c,
                                (state_q != S_IDLE)};
        2'd2:    bus.o_rdata = {29'd0, odd_q, par_en_q, en_q};
        2'd3:    bus.o_rdata = {16'd0, div_q};
        default: bus.o_rdata = 32'd0;
      endcase
    end
  end

  assign o_uart_tx = line_q;
  assign o_busy    = ~empty_c | (state_q != S_IDLE);
endmodule
